// File: rtl/reference_sched_pkg.sv
// Shared types for the reference edge scheduler: FSM state encoding and the
// per-domain configuration record.
package reference_sched_pkg;

  // Width of the stored half-period/phase fields; the top's PERIOD_WIDTH tracks it.
  localparam int CFG_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SEARCH  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  typedef struct packed {
    logic [CFG_WIDTH-1:0] half_period;
    logic [CFG_WIDTH-1:0] phase;
  } domain_cfg_t;

endpackage

// File: rtl/edge_min_reduce.sv
// Balanced min-reduction over per-domain timestamps with an enable mask.
// Returns the minimum and the mask of enabled domains that equal it.
module edge_min_reduce #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]        enable,
  input  logic [N-1:0][W-1:0] times,
  output logic [W-1:0]        min_time,
  output logic [N-1:0]        eq_mask,
  output logic                any_valid
);

  localparam int LEAVES = (N > 1) ? (1 << $clog2(N)) : 1;
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap layout: node k has children 2k+1 and 2k+2, leaves start at LEAVES-1.
  logic [W-1:0] node_val [NODES];
  logic         node_vld [NODES];

  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      node_val[k] = '0;
      node_vld[k] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      node_val[LEAVES-1+i] = times[i];
      node_vld[LEAVES-1+i] = enable[i];
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (node_vld[2*k+1] && (!node_vld[2*k+2] || node_val[2*k+1] <= node_val[2*k+2])) begin
        node_val[k] = node_val[2*k+1];
        node_vld[k] = 1'b1;
      end else begin
        node_val[k] = node_val[2*k+2];
        node_vld[k] = node_vld[2*k+2];
      end
    end
  end

  assign min_time  = node_val[0];
  assign any_valid = node_vld[0];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eq_mask[i] = enable[i] && (times[i] == min_time);
    end
  end

endmodule

// File: rtl/reference_edge_scheduler.sv
// Walks simulated time across several clock domains, emitting one record per
// distinct edge instant with rising/falling domain masks.
module reference_edge_scheduler
  import reference_sched_pkg::*;
#(
  parameter int NUM_DOMAINS  = 4,
  parameter int TIME_WIDTH   = 32,
  parameter int PERIOD_WIDTH = CFG_WIDTH,
  localparam int DOM_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  input  logic [DOM_W-1:0]        cfg_domain,
  input  logic [PERIOD_WIDTH-1:0] cfg_half_period,
  input  logic [PERIOD_WIDTH-1:0] cfg_phase,
  input  logic                    run,
  // edge_valid/edge_ready: a record transfers on a clock edge where both are
  // high; once valid rises, the record and valid are held until that edge.
  output logic                    edge_valid,
  input  logic                    edge_ready,
  output logic [TIME_WIDTH-1:0]   edge_time,
  output logic [NUM_DOMAINS-1:0]  posedge_mask,
  output logic [NUM_DOMAINS-1:0]  negedge_mask,
  output logic                    busy,
  output logic                    overflow,
  output state_t                  debug_state
);

  localparam int SUM_W = ((TIME_WIDTH > PERIOD_WIDTH) ? TIME_WIDTH : PERIOD_WIDTH) + 1;

  state_t state, state_next;
  domain_cfg_t cfg_q [NUM_DOMAINS];

  logic [NUM_DOMAINS-1:0][TIME_WIDTH-1:0] next_time;
  logic [NUM_DOMAINS-1:0][TIME_WIDTH-1:0] advanced;
  logic [SUM_W-1:0]                       sum_ext [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] level, enabled, hit, carry;
  logic [TIME_WIDTH-1:0]  min_time;
  logic any_enabled, cfg_write_ok;
  logic do_load, do_step, do_overflow, do_accept;

  // Widened add so a carry out of TIME_WIDTH is visible per domain.
  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      enabled[i]  = (cfg_q[i].half_period != '0);
      sum_ext[i]  = SUM_W'(next_time[i]) + SUM_W'(cfg_q[i].half_period);
      advanced[i] = sum_ext[i][TIME_WIDTH-1:0];
      carry[i]    = |sum_ext[i][SUM_W-1:TIME_WIDTH];
    end
  end

  edge_min_reduce #(
    .N (NUM_DOMAINS),
    .W (TIME_WIDTH)
  ) u_min_reduce (
    .enable    (enabled),
    .times     (next_time),
    .min_time  (min_time),
    .eq_mask   (hit),
    .any_valid (any_enabled)
  );

  assign cfg_write_ok = (state == IDLE) && cfg_valid && (int'(cfg_domain) < NUM_DOMAINS);
  assign busy         = (state != IDLE);
  assign debug_state  = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_step     = 1'b0;
    do_overflow = 1'b0;
    do_accept   = 1'b0;
    case (state)
      IDLE: if (run && any_enabled && !overflow) state_next = LOAD;
      LOAD: begin
        do_load    = 1'b1;
        state_next = SEARCH;
      end
      SEARCH: begin
        if (!run) begin
          state_next = IDLE;
        end else if (|(hit & carry)) begin
          do_overflow = 1'b1;
          state_next  = IDLE;
        end else begin
          do_step    = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (edge_ready) begin
          do_accept  = 1'b1;
          state_next = run ? SEARCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        cfg_q[i]     <= '0;
        next_time[i] <= '0;
        level[i]     <= 1'b0;
      end
      edge_valid   <= 1'b0;
      edge_time    <= '0;
      posedge_mask <= '0;
      negedge_mask <= '0;
      overflow     <= 1'b0;
    end else begin
      if (cfg_write_ok) begin
        cfg_q[cfg_domain].half_period <= cfg_half_period;
        cfg_q[cfg_domain].phase       <= cfg_phase;
      end
      if (do_load) begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          next_time[i] <= TIME_WIDTH'(cfg_q[i].phase);
          level[i]     <= 1'b0;
        end
      end
      if (do_step) begin
        edge_time  <= min_time;
        edge_valid <= 1'b1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          posedge_mask[i] <= hit[i] & ~level[i];
          negedge_mask[i] <= hit[i] & level[i];
          if (hit[i]) begin
            level[i]     <= ~level[i];
            next_time[i] <= advanced[i];
          end
        end
      end
      if (do_overflow) overflow <= 1'b1;
      if (do_accept) edge_valid <= 1'b0;
    end
  end

endmodule
